h_eqlz_sequencer: RTL

Streams per-resource-element channel estimates to the NB-IoT equaliser for one slot (N_SYM symbols × N_SC subcarriers × NUM_PORTS antenna ports). Holds the two NRS pilot-symbol estimates per subcarrier and port in a local buffer. At pilot positions it outputs the buffered estimate. At data positions it either passes through the interpolator's division result or, in hold mode, repeats the nearest pilot estimate. It sits between the channel-estimation/interpolation datapath and the equaliser. It replaces the single-cycle combinational estimate selector with a counter-driven, handshaked stream.

---
 rtl/nb_chest_pkg.sv | 26 ++
 rtl/pilot_est_buf.sv | 46 ++++
 rtl/h_eqlz_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nb_chest_pkg.sv
// Shared slot geometry defaults and enums for the NB-IoT channel-estimation path.
package nb_chest_pkg;

  localparam int N_SC       = 12;
  localparam int N_SYM      = 7;
  localparam int PILOT_SYM0 = 5;
  localparam int PILOT_SYM1 = 6;

  typedef enum logic {
    MODE_INTERP = 1'b0,
    MODE_HOLD   = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Nearest-pilot choice; ties between the pilots resolve to est1.
  function automatic logic pick_est2(input int sym, input int p0, input int p1);
    if (sym <= p0) return 1'b0;
    if (sym >= p1) return 1'b1;
    return ((sym - p0) > (p1 - sym));
  endfunction

endpackage

// File: rtl/pilot_est_buf.sv
// Pilot estimate store: est1/est2 per (port, subcarrier), one guarded write
// port and combinational reads addressed by the stream counters.
module pilot_est_buf #(
  parameter int  WIDTH     = 16,
  parameter int  N_SC      = 12,
  parameter int  NUM_PORTS = 2,
  localparam int SCW       = $clog2(N_SC)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic             wr_port_i,
  input  logic [SCW-1:0]   wr_sc_i,
  input  logic [WIDTH-1:0] wr_est1_i,
  input  logic [WIDTH-1:0] wr_est2_i,
  input  logic             rd_port_i,
  input  logic [SCW-1:0]   rd_sc_i,
  output logic [WIDTH-1:0] rd_est1_o,
  output logic [WIDTH-1:0] rd_est2_o
);

  localparam int DEPTH = NUM_PORTS * N_SC;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] est1_q [DEPTH];
  logic [WIDTH-1:0] est2_q [DEPTH];

  logic          wr_ok;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Out-of-range coordinates would alias onto another port's entries, so drop them.
  assign wr_ok   = wr_en_i && (int'(wr_sc_i) < N_SC) && (int'(wr_port_i) < NUM_PORTS);
  assign wr_addr = AW'(int'(wr_port_i) * N_SC + int'(wr_sc_i));
  assign rd_addr = AW'(int'(rd_port_i) * N_SC + int'(rd_sc_i));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      est1_q[wr_addr] <= wr_est1_i;
      est2_q[wr_addr] <= wr_est2_i;
    end
  end

  assign rd_est1_o = est1_q[rd_addr];
  assign rd_est2_o = est2_q[rd_addr];

endmodule

// File: rtl/h_eqlz_sequencer.sv
// Streams one slot of per-RE channel estimates to the equaliser: pilot symbols
// from the local buffer, data symbols from the interpolator or a held pilot.
module h_eqlz_sequencer #(
  parameter int  WIDTH      = 16,
  parameter int  N_SC       = nb_chest_pkg::N_SC,
  parameter int  N_SYM      = nb_chest_pkg::N_SYM,
  parameter int  PILOT_SYM0 = nb_chest_pkg::PILOT_SYM0,
  parameter int  PILOT_SYM1 = nb_chest_pkg::PILOT_SYM1,
  parameter int  NUM_PORTS  = 2,
  localparam int SCW        = $clog2(N_SC),
  localparam int SYMW       = $clog2(N_SYM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             est_wr,
  input  logic             est_port,
  input  logic [SCW-1:0]   est_sc,
  input  logic [WIDTH-1:0] est1,
  input  logic [WIDTH-1:0] est2,
  input  logic             mode,
  input  logic             start,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_res,
  output logic             div_ready,
  output logic             h_valid,
  input  logic             h_ready,
  output logic [WIDTH-1:0] h_eqlz,
  output logic             h_port,
  output logic [SYMW-1:0]  h_sym,
  output logic [SCW-1:0]   h_sc,
  output logic             h_last,
  output logic             busy
);

  import nb_chest_pkg::*;

  localparam logic            PORT_LAST = 1'(NUM_PORTS - 1);
  localparam logic [SYMW-1:0] SYM_LAST  = SYMW'(N_SYM - 1);
  localparam logic [SCW-1:0]  SC_LAST   = SCW'(N_SC - 1);
  localparam logic [SYMW-1:0] SYM_P0    = SYMW'(PILOT_SYM0);
  localparam logic [SYMW-1:0] SYM_P1    = SYMW'(PILOT_SYM1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             port_q, port_d;
  logic [SYMW-1:0]  sym_q, sym_d;
  logic [SCW-1:0]   sc_q, sc_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             oport_q, oport_d;
  logic [SYMW-1:0]  osym_q, osym_d;
  logic [SCW-1:0]   osc_q, osc_d;
  logic             last_q, last_d;

  logic             buf_wr;
  logic [WIDTH-1:0] rd_est1;
  logic [WIDTH-1:0] rd_est2;
  logic             is_pilot;
  logic             from_buf;
  logic             use_est2;
  logic             src_valid;
  logic [WIDTH-1:0] src_data;
  logic             active;
  logic             out_free;
  logic             load;
  logic             xfer;
  logic             final_re;

  assign buf_wr = est_wr && (state_q == ST_IDLE);

  pilot_est_buf #(
    .WIDTH    (WIDTH),
    .N_SC     (N_SC),
    .NUM_PORTS(NUM_PORTS)
  ) u_pilot_est_buf (
    .clk      (clk),
    .wr_en_i  (buf_wr),
    .wr_port_i(est_port),
    .wr_sc_i  (est_sc),
    .wr_est1_i(est1),
    .wr_est2_i(est2),
    .rd_port_i(port_q),
    .rd_sc_i  (sc_q),
    .rd_est1_o(rd_est1),
    .rd_est2_o(rd_est2)
  );

  // The counters always point at the next RE to load; done_q freezes them after the last one.
  always_comb begin
    is_pilot  = (sym_q == SYM_P0) || (sym_q == SYM_P1);
    from_buf  = is_pilot || (mode_q == MODE_HOLD);
    use_est2  = pick_est2(int'(sym_q), PILOT_SYM0, PILOT_SYM1);
    src_data  = from_buf ? (use_est2 ? rd_est2 : rd_est1) : div_res;
    src_valid = from_buf || div_valid;
    active    = (state_q == ST_STREAM) && !done_q;
    out_free  = !valid_q || h_ready;
    load      = active && out_free && src_valid;
    xfer      = valid_q && h_ready;
    final_re  = (port_q == PORT_LAST) && (sym_q == SYM_LAST) && (sc_q == SC_LAST);
    div_ready = active && out_free && !from_buf;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    port_d  = port_q;
    sym_d   = sym_q;
    sc_d    = sc_q;
    done_d  = done_q;
    valid_d = valid_q;
    data_d  = data_q;
    oport_d = oport_q;
    osym_d  = osym_q;
    osc_d   = osc_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STREAM;
          mode_d  = mode_e'(mode);
          port_d  = 1'b0;
          sym_d   = '0;
          sc_d    = '0;
          done_d  = 1'b0;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) state_d = ST_IDLE;
        end
        if (load) begin
          valid_d = 1'b1;
          data_d  = src_data;
          oport_d = port_q;
          osym_d  = sym_q;
          osc_d   = sc_q;
          last_d  = final_re;
          if (final_re) begin
            done_d = 1'b1;
          end else if (sc_q != SC_LAST) begin
            sc_d = sc_q + 1'b1;
          end else begin
            sc_d = '0;
            if (sym_q != SYM_LAST) begin
              sym_d = sym_q + 1'b1;
            end else begin
              sym_d  = '0;
              port_d = port_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_INTERP;
      port_q  <= 1'b0;
      sym_q   <= '0;
      sc_q    <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      oport_q <= 1'b0;
      osym_q  <= '0;
      osc_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      port_q  <= port_d;
      sym_q   <= sym_d;
      sc_q    <= sc_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      oport_q <= oport_d;
      osym_q  <= osym_d;
      osc_q   <= osc_d;
      last_q  <= last_d;
    end
  end

  assign h_valid = valid_q;
  assign h_eqlz  = data_q;
  assign h_port  = oport_q;
  assign h_sym   = osym_q;
  assign h_sc    = osc_q;
  assign h_last  = last_q;
  assign busy    = (state_q == ST_STREAM);

endmodule
